// File: rtl/joystick_event_gen.sv
// Joystick direction debouncer and press/auto-repeat event generator.
// Debounced direction changes and repeats are queued in a small FIFO for the consumer.
module joystick_event_gen #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 150000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       joystick_up,
    input  logic       joystick_down,
    input  logic       joystick_left,
    input  logic       joystick_right,
    input  logic       evt_ready,
    input  logic       ovf_clr,
    output logic       evt_valid,
    output logic [1:0] evt_dir,
    output logic       evt_repeat,
    output logic       evt_overflow,
    output logic [2:0] held_dir
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EV_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int EV_W   = (EV_MAX > 1) ? $clog2(EV_MAX) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [DB_W-1:0]  DB_TARGET   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [EV_W-1:0]  DELAY_LAST  = EV_W'(REPEAT_DELAY - 1);
    localparam logic [EV_W-1:0]  PERIOD_LAST = EV_W'(REPEAT_PERIOD - 1);
    localparam logic [PTR_W:0]   FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    typedef struct packed {
        logic       rpt;
        logic [1:0] dir;
    } evt_t;

    function automatic logic [1:0] dir_code(input dir_t d);
        return 2'(d - DIR_UP);
    endfunction

    logic [3:0]      joy_q;   // {right, left, down, up}
    dir_t            raw_dir;
    dir_t            db_cand;
    dir_t            held;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_next;

    always_comb begin
        // NOTE: combinational outputs get a default first so no path can infer a latch.
        raw_dir = DIR_NONE;
        if (joy_q[0])      raw_dir = DIR_UP;
        else if (joy_q[1]) raw_dir = DIR_DOWN;
        else if (joy_q[2]) raw_dir = DIR_LEFT;
        else if (joy_q[3]) raw_dir = DIR_RIGHT;
    end

    // db_next counts consecutive cycles raw_dir has matched the candidate, saturating at the target.
    always_comb begin
        db_next = db_cnt + DB_W'(1);
        if (raw_dir != db_cand)      db_next = DB_W'(1);
        else if (db_cnt == DB_TARGET) db_next = db_cnt;
    end

    always_ff @(posedge clk_1MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            joy_q   <= '0;
            db_cand <= DIR_NONE;
            db_cnt  <= '0;
            held    <= DIR_NONE;
        end else begin
            joy_q   <= {joystick_right, joystick_left, joystick_down, joystick_up};
            db_cand <= raw_dir;
            db_cnt  <= db_next;
            if (db_next == DB_TARGET) held <= raw_dir;
        end
    end

    assign held_dir = held;

    state_t          state, state_nxt;
    dir_t            cur_dir, dir_nxt;
    logic [EV_W-1:0] ev_cnt, cnt_nxt;
    logic            push;
    evt_t            push_evt;

    always_comb begin
        state_nxt = state;
        dir_nxt   = cur_dir;
        cnt_nxt   = ev_cnt + EV_W'(1);
        push      = 1'b0;
        push_evt  = '0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (held != DIR_NONE) begin
                    push      = 1'b1;
                    push_evt  = '{rpt: 1'b0, dir: dir_code(held)};
                    dir_nxt   = held;
                    state_nxt = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (held == DIR_NONE) begin
                    state_nxt = S_IDLE;
                    dir_nxt   = DIR_NONE;
                    cnt_nxt   = '0;
                end else if (held != cur_dir) begin
                    push      = 1'b1;
                    push_evt  = '{rpt: 1'b0, dir: dir_code(held)};
                    dir_nxt   = held;
                    state_nxt = S_DELAY;
                    cnt_nxt   = '0;
                end else if ((state == S_DELAY  && ev_cnt == DELAY_LAST) ||
                             (state == S_REPEAT && ev_cnt == PERIOD_LAST)) begin
                    push      = 1'b1;
                    push_evt  = '{rpt: 1'b1, dir: dir_code(cur_dir)};
                    state_nxt = S_REPEAT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                dir_nxt   = DIR_NONE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_dir <= DIR_NONE;
            ev_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            cur_dir <= dir_nxt;
            ev_cnt  <= cnt_nxt;
        end
    end

    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, wr_en;
    evt_t             head;

    assign full      = (count == FIFO_FULL);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    // A pop frees the slot this same edge, so a push on a full queue still fits.
    assign wr_en     = push && (!full || pop);

    // NOTE: queue storage is not reset; the reset count/pointers make stale entries unreachable.
    always_ff @(posedge clk_1MHz) begin
        if (wr_en) mem[wr_ptr] <= push_evt;
    end

    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (!wr_en && pop) count <= count - (PTR_W + 1)'(1);
            evt_overflow <= (push && full && !pop) || (evt_overflow && !ovf_clr);
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_dir    = evt_valid ? head.dir : 2'b00;
    assign evt_repeat = evt_valid && head.rpt;

endmodule

// File: tb/tb_joystick_event_gen.sv
// Scoreboard bench for joystick_event_gen: expected events are queued as stimulus is driven
// and compared (direction, repeat flag, and push edge where timing is fixed) as the DUT pops them.
module tb_joystick_event_gen;

    localparam int D  = 4;
    localparam int R  = 10;
    localparam int RP = 5;

    logic       clk_1MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       joystick_up = 1'b0, joystick_down = 1'b0, joystick_left = 1'b0, joystick_right = 1'b0;
    logic       evt_ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_dir;
    logic       evt_repeat;
    logic       evt_overflow;
    logic [2:0] held_dir;

    joystick_event_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (R),
        .REPEAT_PERIOD  (RP),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_1MHz      (clk_1MHz),
        .rst_n         (rst_n),
        .joystick_up   (joystick_up),
        .joystick_down (joystick_down),
        .joystick_left (joystick_left),
        .joystick_right(joystick_right),
        .evt_ready     (evt_ready),
        .ovf_clr       (ovf_clr),
        .evt_valid     (evt_valid),
        .evt_dir       (evt_dir),
        .evt_repeat    (evt_repeat),
        .evt_overflow  (evt_overflow),
        .held_dir      (held_dir)
    );

    initial forever #5 clk_1MHz = ~clk_1MHz;

    typedef struct {
        logic [1:0] dir;
        logic       rpt;
        int         cyc;
        bit         timed;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   spurious = 0;

    always @(posedge clk_1MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pops are taken at the falling edge, i.e. just before the rising edge that performs them.
    always @(negedge clk_1MHz) begin
        exp_t e;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                spurious++;
            end else begin
                e = exp_q.pop_front();
                if (e.timed)
                    check("evt_timed", {cyc[28:0], evt_dir, evt_repeat}, {e.cyc[28:0], e.dir, e.rpt});
                else
                    check("evt_order", {29'd0, evt_dir, evt_repeat}, {29'd0, e.dir, e.rpt});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_1MHz);
            #1;
        end
    endtask

    task automatic exp_push(input logic [1:0] dir, input logic rpt, input int at, input bit timed);
        exp_t e;
        e.dir = dir; e.rpt = rpt; e.cyc = at; e.timed = timed;
        exp_q.push_back(e);
    endtask

    // Direction visible to the event FSM at edges first..last: press at first, repeats
    // REPEAT_DELAY later and then every REPEAT_PERIOD while still held.
    task automatic expect_hold(input logic [1:0] dir, input int first, input int last);
        exp_push(dir, 1'b0, first, 1'b1);
        for (int t = first + R; t <= last; t += RP) exp_push(dir, 1'b1, t, 1'b1);
    endtask

    task automatic settle_check(input string tag);
        check({tag, "_spurious"}, spurious, 0);
        check({tag, "_missing"}, exp_q.size(), 0);
    endtask

    int k;
    int k2;
    bit held_seen;

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_dir", evt_dir, 0);
        check("rst_repeat", evt_repeat, 0);
        check("rst_ovf", evt_overflow, 0);
        check("rst_held", held_dir, 0);
        rst_n = 1'b1;
        tick(5);

        // Up held 30 cycles: press, delayed repeat, periodic repeats, nothing after release
        k = cyc;
        joystick_up = 1'b1;
        expect_hold(2'b00, k + D + 2, k + 31 + D);
        tick(4);
        check("up_held_early", held_dir, 0);
        tick(1);
        check("up_held_on", held_dir, 1);
        tick(25);
        joystick_up = 1'b0;
        tick(5);
        check("up_held_off", held_dir, 0);
        tick(20);
        settle_check("up");

        // Left glitches shorter than the debounce window
        held_seen = 1'b0;
        for (int p = 0; p < 4; p++) begin
            joystick_left = 1'b1;
            for (int i = 0; i < 3; i++) begin tick(1); if (held_dir !== 3'd0) held_seen = 1'b1; end
            joystick_left = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(1); if (held_dir !== 3'd0) held_seen = 1'b1; end
        end
        check("glitch_held", held_seen, 0);
        tick(10);
        settle_check("glitch");

        // Up and right together: up wins; dropping up yields a right press
        k = cyc;
        joystick_up = 1'b1;
        joystick_right = 1'b1;
        expect_hold(2'b00, k + 6, k + 17);
        expect_hold(2'b11, k + 18, k + 25);
        tick(12);
        joystick_up = 1'b0;
        tick(5);
        check("prio_right_held", held_dir, 4);
        tick(3);
        joystick_right = 1'b0;
        tick(20);
        settle_check("prio");

        // Consumer stalled: four queued, later pushes dropped, overflow set wins over clear
        k = cyc;
        evt_ready = 1'b0;
        joystick_down = 1'b1;
        exp_push(2'b01, 1'b0, 0, 1'b0);
        exp_push(2'b01, 1'b1, 0, 1'b0);
        exp_push(2'b01, 1'b1, 0, 1'b0);
        exp_push(2'b01, 1'b1, 0, 1'b0);
        tick(20);
        check("stall_head_mid", {evt_valid, evt_dir, evt_repeat}, 4'b1010);
        tick(7);
        check("stall_ovf_pre", evt_overflow, 0);
        ovf_clr = 1'b1;
        tick(4);
        check("ovf_set_wins", evt_overflow, 1);
        ovf_clr = 1'b0;
        tick(9);
        joystick_down = 1'b0;
        tick(10);
        check("stall_head_end", {evt_valid, evt_dir, evt_repeat}, 4'b1010);
        check("stall_ovf", evt_overflow, 1);
        evt_ready = 1'b1;
        tick(6);
        check("drain_empty", evt_valid, 0);
        check("ovf_sticky", evt_overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", evt_overflow, 0);
        tick(5);
        settle_check("stall");

        // Full queue with simultaneous push and pop
        k = cyc;
        evt_ready = 1'b0;
        joystick_right = 1'b1;
        exp_push(2'b11, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) exp_push(2'b11, 1'b1, 0, 1'b0);
        tick(30);
        joystick_right = 1'b0;
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tick(5);
        check("full_pp_ovf", evt_overflow, 0);
        check("full_pp_head", {evt_valid, evt_dir, evt_repeat}, 4'b1111);
        evt_ready = 1'b1;
        tick(3);
        check("full_pp_occ3", evt_valid, 1);
        tick(1);
        check("full_pp_occ4", evt_valid, 0);
        tick(5);
        settle_check("fullpp");

        // Reset during repeat with queued events
        k = cyc;
        evt_ready = 1'b0;
        joystick_up = 1'b1;
        tick(18);
        check("pre_rst_valid", evt_valid, 1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_out", {evt_dir, evt_repeat, evt_overflow}, 0);
        check("mid_rst_held", held_dir, 0);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        k2 = cyc;
        expect_hold(2'b00, k2 + 6, k2 + 13);
        tick(4);
        check("post_rst_held_early", held_dir, 0);
        tick(1);
        check("post_rst_held_on", held_dir, 1);
        tick(3);
        joystick_up = 1'b0;
        tick(20);
        settle_check("rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
